countdown_ctrl: RTL and testbench

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

---
 rtl/countdown_ctrl.sv | 106 ++++++++++
 tb/tb_countdown_ctrl.sv | 123 ++++++++++++
 2 files changed

// File: rtl/countdown_ctrl.sv
// countdown_ctrl: start/pause/alarm controller and BCD preset for a two-digit down counter
module countdown_ctrl #(
   parameter int ALARM_TICKS = 10,
   parameter int TENS_MAX    = 5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       sw_set,
   input  logic       btn_start,
   input  logic       btn_clr,
   input  logic       btn_inc_unit,
   input  logic       btn_inc_tens,
   input  logic       cnt_zero,
   output logic       decrease,
   output logic       load,
   output logic       setting,
   output logic [3:0] preset_unit,
   output logic [3:0] preset_tens,
   output logic       alarm,
   output logic [1:0] state
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, ALARM = 2'b11} state_t;
   localparam int CW = ALARM_TICKS > 1 ? $clog2(ALARM_TICKS) : 1;
   state_t        state_q;
   logic [CW-1:0] tick_cnt_q;
   logic [3:0]    unit_q, tens_q, unit_d, tens_d;
   logic          dec_q, load_q, set_q, alarm_q, inc_ok, preset_chg;
   always_comb begin
      inc_ok     = state_q == IDLE && sw_set;
      unit_d     = inc_ok && btn_inc_unit ? (unit_q == 4'd9 ? 4'd0 : unit_q + 4'd1) : unit_q;
      tens_d     = inc_ok && btn_inc_tens ? (tens_q == 4'(TENS_MAX) ? 4'd0 : tens_q + 4'd1) : tens_q;
      preset_chg = unit_d != unit_q || tens_d != tens_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tick_cnt_q <= '0;
         unit_q     <= 4'd0;
         tens_q     <= 4'd3;
         dec_q      <= 1'b0;
         load_q     <= 1'b0;
         set_q      <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         dec_q  <= 1'b0;
         load_q <= 1'b0;
         unit_q <= unit_d;
         tens_q <= tens_d;
         case (state_q)
            IDLE: begin
               set_q  <= sw_set;
               load_q <= btn_clr | preset_chg;
               if (!btn_clr && btn_start && !sw_set && {tens_q, unit_q} != 8'd0) begin
                  state_q <= RUN;
                  set_q   <= 1'b0;
               end
            end
            RUN: begin
               if (btn_clr) begin
                  state_q <= IDLE;
                  load_q  <= 1'b1;
                  set_q   <= sw_set;
               end else if (btn_start) begin
                  state_q <= PAUSE;
               end else if (tick && cnt_zero) begin
                  state_q    <= ALARM;
                  alarm_q    <= 1'b1;
                  tick_cnt_q <= '0;
               end else if (tick) begin
                  dec_q <= 1'b1;
               end
            end
            PAUSE: begin
               if (btn_clr) begin
                  state_q <= IDLE;
                  load_q  <= 1'b1;
                  set_q   <= sw_set;
               end else if (btn_start) begin
                  state_q <= RUN;
               end
            end
            ALARM: begin
               // the final alarm tick leaves straight to IDLE rather than toggling once more
               if (btn_clr || btn_start || (tick && tick_cnt_q == CW'(ALARM_TICKS - 1))) begin
                  state_q    <= IDLE;
                  load_q     <= 1'b1;
                  set_q      <= sw_set;
                  alarm_q    <= 1'b0;
                  tick_cnt_q <= '0;
               end else if (tick) begin
                  alarm_q    <= ~alarm_q;
                  tick_cnt_q <= tick_cnt_q + CW'(1);
               end
            end
         endcase
      end
   end
   assign decrease    = dec_q;
   assign load        = load_q;
   assign setting     = set_q;
   assign preset_unit = unit_q;
   assign preset_tens = tens_q;
   assign alarm       = alarm_q;
   assign state       = state_q;
endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl: table-driven vectors with an expected-output queue, plus async reset corner
module tb_countdown_ctrl;
   logic       clk, rst_n, tick, sw_set, btn_start, btn_clr, btn_inc_unit, btn_inc_tens, cnt_zero;
   logic       decrease, load, setting, alarm;
   logic [3:0] preset_unit, preset_tens;
   logic [1:0] state;
   countdown_ctrl #(.ALARM_TICKS(10), .TENS_MAX(5)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .sw_set(sw_set), .btn_start(btn_start),
      .btn_clr(btn_clr), .btn_inc_unit(btn_inc_unit), .btn_inc_tens(btn_inc_tens),
      .cnt_zero(cnt_zero), .decrease(decrease), .load(load), .setting(setting),
      .preset_unit(preset_unit), .preset_tens(preset_tens), .alarm(alarm), .state(state)
   );
   localparam logic [6:0] C = 7'b1000000, S = 7'b0100000, T = 7'b0010000, W = 7'b0001000,
                          U = 7'b0000100, N = 7'b0000010, Z = 7'b0000001, O = 7'b0000000;
   localparam logic [1:0] I = 2'd0, R = 2'd1, P = 2'd2, A = 2'd3;
   typedef struct {
      logic [6:0]  in;
      logic [13:0] exp;
   } vec_t;
   vec_t        tbl[$];
   logic [13:0] exp_q[$];
   int          n_cmp = 0, n_bad = 0, step = 0;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   function automatic logic [13:0] e(input logic d, l, s, a, input logic [1:0] st, input int pu, pt);
      return {d, l, s, a, st, 4'(pu), 4'(pt)};
   endfunction
   task automatic add(input logic [6:0] in, input logic [13:0] ex);
      vec_t v;
      v.in  = in;
      v.exp = ex;
      tbl.push_back(v);
   endtask
   task automatic check();
      logic [13:0] ex, act;
      act = {decrease, load, setting, alarm, state, preset_unit, preset_tens};
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL step %0d: no expected entry queued, got %b", step, act);
      end else begin
         ex = exp_q.pop_front();
         if (act !== ex)  begin
            n_bad++;
            $display("FAIL step %0d {dec,ld,set,alm,st,pu,pt}: got %b_%b_%b_%b_%b_%0d_%0d want %b_%b_%b_%b_%b_%0d_%0d",
                     step, act[13], act[12], act[11], act[10], act[9:8], act[7:4], act[3:0],
                     ex[13], ex[12], ex[11], ex[10], ex[9:8], ex[7:4], ex[3:0]);
         end
      end
      step++;
   endtask
   task automatic apply(input logic [6:0] in, input logic [13:0] ex);
      {btn_clr, btn_start, tick, sw_set, btn_inc_unit, btn_inc_tens, cnt_zero} = in;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      check();
   endtask
   initial begin
      rst_n = 1'b1;
      {btn_clr, btn_start, tick, sw_set, btn_inc_unit, btn_inc_tens, cnt_zero} = O;
      add(W, e(0, 0, 1, 0, I, 0, 3));
      for (int k = 1; k <= 12; k++) add(U | W, e(0, 1, 1, 0, I, k % 10, 3));
      for (int j = 1; j <= 7; j++) add(N | W, e(0, 1, 1, 0, I, 2, (3 + j) % 6));
      add(U | N | W, e(0, 1, 1, 0, I, 3, 5));
      add(N | W, e(0, 1, 1, 0, I, 3, 0));
      add(S | W, e(0, 0, 1, 0, I, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(U, e(0, 0, 0, 0, R, 3, 0));
      add(U | W, e(0, 0, 0, 0, R, 3, 0));
      add(T, e(1, 0, 0, 0, R, 3, 0));
      add(O, e(0, 0, 0, 0, R, 3, 0));
      add(T, e(1, 0, 0, 0, R, 3, 0));
      add(T, e(1, 0, 0, 0, R, 3, 0));
      add(T | Z, e(0, 0, 0, 1, A, 3, 0));
      add(Z, e(0, 0, 0, 1, A, 3, 0));
      for (int k = 1; k <= 9; k++) add(T | Z, e(0, 0, 0, logic'(~k[0]), A, 3, 0));
      add(T | Z, e(0, 1, 0, 0, I, 3, 0));
      add(O, e(0, 0, 0, 0, I, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(T, e(1, 0, 0, 0, R, 3, 0));
      add(S | T, e(0, 0, 0, 0, P, 3, 0));
      for (int k = 0; k < 3; k++) add(T, e(0, 0, 0, 0, P, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(T, e(1, 0, 0, 0, R, 3, 0));
      add(C | S | T, e(0, 1, 0, 0, I, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(T | Z, e(0, 0, 0, 1, A, 3, 0));
      add(T | Z, e(0, 0, 0, 0, A, 3, 0));
      add(S | Z, e(0, 1, 0, 0, I, 3, 0));
      add(C, e(0, 1, 0, 0, I, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(S, e(0, 0, 0, 0, P, 3, 0));
      add(C, e(0, 1, 0, 0, I, 3, 0));
      add(S, e(0, 0, 0, 0, R, 3, 0));
      add(T | Z, e(0, 0, 0, 1, A, 3, 0));
      add(C | T | W | Z, e(0, 1, 1, 0, I, 3, 0));
      for (int k = 1; k <= 7; k++) add(U | W, e(0, 1, 1, 0, I, (3 + k) % 10, 0));
      add(S, e(0, 0, 0, 0, I, 0, 0));
      add(U | W, e(0, 1, 1, 0, I, 1, 0));
      add(S, e(0, 0, 0, 0, R, 1, 0));
      add(T | Z, e(0, 0, 0, 1, A, 1, 0));
      #1 rst_n = 1'b0;
      #2;
      exp_q.push_back(e(0, 0, 0, 0, I, 0, 3));
      check();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < tbl.size(); i++) apply(tbl[i].in, tbl[i].exp);
      {btn_clr, btn_start, tick, sw_set, btn_inc_unit, btn_inc_tens, cnt_zero} = O;
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back(e(0, 0, 0, 0, I, 0, 3));
      check();
      @(posedge clk);
      #1 rst_n = 1'b1;
      apply(O, e(0, 0, 0, 0, I, 0, 3));
      apply(O, e(0, 0, 0, 0, I, 0, 3));
      apply(C, e(0, 1, 0, 0, I, 0, 3));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
